// File: rtl/ddr_rd_req_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ddr_rd_req_arb_if
// Brief   : Request/ack, DDR read-command and read-data strobe bundle.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
interface ddr_rd_req_arb_if #(
  parameter int TOTAL_PROG_NUM = 256,
  parameter int PROG_BIT_WIDTH = 8
);
  logic [TOTAL_PROG_NUM-1:0] ddr_rd_data_req;
  logic [TOTAL_PROG_NUM-1:0] ddr_rd_data_ack;
  logic [TOTAL_PROG_NUM-1:0] head_val;
  logic                      rd_cmd_valid;
  logic                      rd_cmd_rdy;
  logic [PROG_BIT_WIDTH-1:0] rd_cmd_prog;
  logic                      rd_data_valid;
  logic                      rd_err;

  // master: the arbiter; slave: requesters plus DDR controller
  modport master (
    input  ddr_rd_data_req,
    input  rd_cmd_rdy,
    input  rd_data_valid,
    output ddr_rd_data_ack,
    output head_val,
    output rd_cmd_valid,
    output rd_cmd_prog,
    output rd_err
  );

  modport slave (
    output ddr_rd_data_req,
    output rd_cmd_rdy,
    output rd_data_valid,
    input  ddr_rd_data_ack,
    input  head_val,
    input  rd_cmd_valid,
    input  rd_cmd_prog,
    input  rd_err
  );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_req_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ddr_rd_req_arb
// Brief   : Round-robin arbiter issuing one DDR burst read per program request.
//           Optional watchdog compiled in with macro RD_ARB_WATCHDOG_EN.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module ddr_rd_req_arb #(
  parameter int TOTAL_PROG_NUM = 256,
  parameter int PROG_BIT_WIDTH = 8,
  parameter int BURST_WORDS    = 12,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ddr_rd_req_arb_if.master bus
);

  localparam int                      c_cnt_w     = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [c_cnt_w-1:0]      c_last_word = c_cnt_w'(BURST_WORDS - 1);
  localparam logic [PROG_BIT_WIDTH:0] c_prog_num  = (PROG_BIT_WIDTH + 1)'(TOTAL_PROG_NUM);
  localparam logic [PROG_BIT_WIDTH-1:0] c_last_prog = PROG_BIT_WIDTH'(TOTAL_PROG_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  if (TOTAL_PROG_NUM < 2 || (1 << PROG_BIT_WIDTH) < TOTAL_PROG_NUM ||
      BURST_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ddr_rd_req_arb: inconsistent parameter set");
  end

  state_t                    r_state;
  logic [PROG_BIT_WIDTH-1:0] r_rr_ptr;
  logic [PROG_BIT_WIDTH-1:0] r_grant_idx;
  logic [c_cnt_w-1:0]        r_word_cnt;
  logic                      r_cmd_valid;
  logic [TOTAL_PROG_NUM-1:0] r_ack;

  logic                      w_req_hit;
  logic [PROG_BIT_WIDTH-1:0] w_next_idx;
  logic [PROG_BIT_WIDTH:0]   w_pos;
  logic [PROG_BIT_WIDTH-1:0] w_ptr_after;
  logic [TOTAL_PROG_NUM-1:0] w_grant_oh;
  logic [TOTAL_PROG_NUM-1:0] w_head;
  logic                      w_last_word;

  // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_req_hit  = 1'b0;
    w_next_idx = '0;
    w_pos      = '0;
    for (int i = TOTAL_PROG_NUM - 1; i >= 0; i--) begin
      w_pos = {1'b0, r_rr_ptr} + (PROG_BIT_WIDTH + 1)'(i);
      if (w_pos >= c_prog_num) begin
        w_pos = w_pos - c_prog_num;
      end
      if (bus.ddr_rd_data_req[w_pos[PROG_BIT_WIDTH-1:0]]) begin
        w_req_hit  = 1'b1;
        w_next_idx = w_pos[PROG_BIT_WIDTH-1:0];
      end
    end
  end

  assign w_ptr_after = (r_grant_idx == c_last_prog) ? '0 : r_grant_idx + 1'b1;
  assign w_grant_oh  = {{(TOTAL_PROG_NUM-1){1'b0}}, 1'b1} << r_grant_idx;
  assign w_last_word = (r_state == S_DATA) && bus.rd_data_valid && (r_word_cnt == c_last_word);
  assign w_head      = ((r_state == S_DATA) && bus.rd_data_valid && (r_word_cnt == '0))
                       ? w_grant_oh : '0;

`ifdef RD_ARB_WATCHDOG_EN
  localparam int                 c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0]  c_wd_fire = c_wd_w'(TIMEOUT_CYCLES - 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              r_err;
  logic              w_timeout;

  // Fires in the cycle before the count reaches the limit so the pulse lands on it.
  assign w_timeout  = (r_wd_cnt >= c_wd_fire);
  assign bus.rd_err = r_err;
`else
  assign bus.rd_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_word_cnt  <= '0;
      r_cmd_valid <= 1'b0;
      r_ack       <= '0;
`ifdef RD_ARB_WATCHDOG_EN
      r_wd_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef RD_ARB_WATCHDOG_EN
      r_err <= 1'b0;
      if (r_state == S_CMD || r_state == S_DATA) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_req_hit) begin
            r_grant_idx <= w_next_idx;
            r_cmd_valid <= 1'b1;
            r_state     <= S_CMD;
`ifdef RD_ARB_WATCHDOG_EN
            r_wd_cnt    <= '0;
`endif
          end
        end
        S_CMD: begin
          if (bus.rd_cmd_rdy) begin
            r_cmd_valid <= 1'b0;
            r_word_cnt  <= '0;
            r_state     <= S_DATA;
          end
`ifdef RD_ARB_WATCHDOG_EN
          else if (w_timeout) begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b1;
            r_rr_ptr    <= w_ptr_after;
            r_state     <= S_GAP;
          end
`endif
        end
        S_DATA: begin
          if (w_last_word) begin
            r_ack   <= w_grant_oh;
            r_state <= S_DONE;
          end else begin
            if (bus.rd_data_valid) begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
`ifdef RD_ARB_WATCHDOG_EN
            if (w_timeout) begin
              r_err    <= 1'b1;
              r_rr_ptr <= w_ptr_after;
              r_state  <= S_GAP;
            end
`endif
          end
        end
        S_DONE: begin
          r_rr_ptr <= w_ptr_after;
          r_state  <= S_GAP;
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ddr_rd_data_ack = r_ack;
  assign bus.head_val        = w_head;
  assign bus.rd_cmd_valid    = r_cmd_valid;
  assign bus.rd_cmd_prog     = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_req_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_ddr_rd_req_arb
// Brief   : Directed self-checking bench for ddr_rd_req_arb.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_ddr_rd_req_arb;
  localparam int N  = 256;
  localparam int W  = 8;
  localparam int BW = 12;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ddr_rd_req_arb_if #(.TOTAL_PROG_NUM(N), .PROG_BIT_WIDTH(W)) bus ();

  ddr_rd_req_arb #(
    .TOTAL_PROG_NUM(N),
    .PROG_BIT_WIDTH(W),
    .BURST_WORDS   (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  bus.ddr_rd_data_ack, '0);
    chk({tag, "_head"}, bus.head_val, '0);
    chk({tag, "_vld"},  bus.rd_cmd_valid, '0);
    chk({tag, "_prog"}, bus.rd_cmd_prog, '0);
    chk({tag, "_err"},  bus.rd_err, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ddr_rd_data_req = '0;
    bus.rd_data_valid   = 1'b0;
    bus.rd_cmd_rdy      = 1'b0;
    tick();
    tick();
    #1;
    chk_all_zero("rst");
    rst = 1'b0;
  endtask

  // Runs one transaction from its IDLE cycle through GAP; the owner drops its request in GAP.
  task automatic txn(input int idx, input int rdy_dly, input int period, input bit stray);
    int words;
    int cyc;
    bit v;
    bus.rd_data_valid = stray;
    bus.rd_cmd_rdy    = 1'b0;
    #1;
    chk("idle_vld",  bus.rd_cmd_valid, '0);
    chk("idle_head", bus.head_val, '0);
    tick();
    for (int k = 0; k < rdy_dly; k++) begin
      bus.rd_data_valid = 1'b0;
      #1;
      chk("wait_vld",  bus.rd_cmd_valid, 1);
      chk("wait_prog", bus.rd_cmd_prog, idx);
      tick();
    end
    bus.rd_data_valid = 1'b0;
    bus.rd_cmd_rdy    = 1'b1;
    #1;
    chk("cmd_vld",  bus.rd_cmd_valid, 1);
    chk("cmd_prog", bus.rd_cmd_prog, idx);
    tick();
    bus.rd_cmd_rdy = 1'b0;
    words = 0;
    cyc   = 0;
    while (words < BW && cyc < 400) begin
      v = ((cyc % period) == 0);
      bus.rd_data_valid = v;
      #1;
      if (cyc == 0) chk("one_accept", bus.rd_cmd_valid, '0);
      chk("head", bus.head_val, (v && words == 0) ? oh(idx) : '0);
      chk("early_ack", bus.ddr_rd_data_ack, '0);
      if (v) words++;
      cyc++;
      tick();
    end
    chk("burst_words", words, BW);
    bus.rd_data_valid = stray;
    #1;
    chk("ack", bus.ddr_rd_data_ack, oh(idx));
    chk("done_head", bus.head_val, '0);
    chk("done_err", bus.rd_err, '0);
    tick();
    bus.ddr_rd_data_req[idx] = 1'b0;
    bus.rd_data_valid = stray;
    #1;
    chk("gap_ack", bus.ddr_rd_data_ack, '0);
    chk("gap_vld", bus.rd_cmd_valid, '0);
    tick();
    bus.rd_data_valid = 1'b0;
  endtask

  initial begin
    int  err_at;
    bit  ack_seen;
    bit  err_seen;
    rst = 1'b1;
    bus.ddr_rd_data_req = '0;
    bus.rd_data_valid   = 1'b0;
    bus.rd_cmd_rdy      = 1'b0;
    do_reset();

    // Single request, back-to-back data
    bus.ddr_rd_data_req = oh(5);
    txn(5, 0, 1, 1'b0);

    // Round-robin order with wrap from 255 back to 3
    do_reset();
    bus.ddr_rd_data_req = oh(3) | oh(200) | oh(255);
    txn(3, 0, 1, 1'b0);
    txn(200, 0, 1, 1'b0);
    txn(255, 0, 1, 1'b0);
    bus.ddr_rd_data_req[3] = 1'b1;
    txn(3, 0, 1, 1'b0);

    // Command back-pressure for 10 cycles
    bus.ddr_rd_data_req = oh(100);
    txn(100, 10, 1, 1'b0);

    // Gapped data plus stray valids outside DATA
    bus.ddr_rd_data_req = oh(17);
    txn(17, 0, 3, 1'b1);

    // Data withheld after command accept
    bus.ddr_rd_data_req = oh(9);
    #1;
    tick();
    bus.rd_cmd_rdy = 1'b1;
    #1;
    chk("wd_cmd_prog", bus.rd_cmd_prog, 9);
    err_at   = -1;
    ack_seen = 1'b0;
    err_seen = 1'b0;
    for (int n = 1; n <= 1100 && err_at < 0; n++) begin
      tick();
      bus.rd_cmd_rdy = 1'b0;
      #1;
      if (bus.ddr_rd_data_ack != '0) ack_seen = 1'b1;
      if (bus.rd_err) begin
        err_seen = 1'b1;
        err_at   = n;
      end
    end
    chk("wd_no_ack", ack_seen, '0);
`ifdef RD_ARB_WATCHDOG_EN
    chk("wd_latency", err_at, TO);
    bus.ddr_rd_data_req = oh(60);
    tick();
    #1;
    chk("wd_pulse", bus.rd_err, '0);
    txn(60, 0, 1, 1'b0);
`else
    chk("wd_absent", err_seen, '0);
    do_reset();
`endif

    // Reset in the middle of a burst, then a clean transaction
    bus.ddr_rd_data_req = oh(40);
    #1;
    tick();
    bus.rd_cmd_rdy = 1'b1;
    tick();
    bus.rd_cmd_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.rd_data_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rd_data_valid   = 1'b0;
    bus.ddr_rd_data_req = '0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    #1;
    chk("post_rst_ack", bus.ddr_rd_data_ack, '0);
    chk("post_rst_vld", bus.rd_cmd_valid, '0);
    bus.ddr_rd_data_req = oh(77);
    txn(77, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
